// File: rtl/mdu.sv
// MIPS execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to enable op 6 (madd: {HI,LO} += signed a * signed b).
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, sq_mag, sr_mag, sq, sr, uq, ur;
  logic [31:0] res_hi, res_lo;
  logic        res_we;
  logic        multi_op, mult_class, done, accept;

  // Products are taken modulo 2^64, so sign-extending to 64 bits gives the signed result.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed division through magnitudes; 0x80000000 / -1 naturally wraps to 0x80000000, rem 0.
  assign a_mag  = a_q[31] ? -a_q : a_q;
  assign b_mag  = b_q[31] ? -b_q : b_q;
  assign sq_mag = a_mag / b_mag;
  assign sr_mag = a_mag % b_mag;
  assign sq     = (a_q[31] ^ b_q[31]) ? -sq_mag : sq_mag;
  assign sr     = a_q[31] ? -sr_mag : sr_mag;
  assign uq     = a_q / b_q;
  assign ur     = a_q % b_q;

  always_comb begin
    res_we = 1'b1;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      3'd2: begin
        if (b_q == '0) res_we = 1'b0;
        else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      3'd3: begin
        if (b_q == '0) res_we = 1'b0;
        else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
`ifdef MDU_MADD_EN
      3'd6: {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
`endif
      default: res_we = 1'b0;
    endcase
  end

  always_comb begin
    multi_op   = (op <= 3'd3);
    mult_class = (op == 3'd0) || (op == 3'd1);
`ifdef MDU_MADD_EN
    multi_op   = multi_op || (op == 3'd6);
    mult_class = mult_class || (op == 3'd6);
`endif
  end

  // The completion edge also accepts a new start, enabling back-to-back issue.
  assign done   = (state_q == RUN) && (cnt_q == 32'd1);
  assign accept = start && ((state_q == IDLE) || done);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == RUN) begin
      if (done) begin
        state_d = IDLE;
        cnt_d   = '0;
        if (res_we) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
    if (accept) begin
      if (multi_op) begin
        a_d     = a;
        b_d     = b;
        op_d    = op;
        cnt_d   = mult_class ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
        state_d = RUN;
      end else if (op == 3'd4) begin
        hi_d = a;
      end else if (op == 3'd5) begin
        lo_d = a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
